// File: rtl/affine_pkg.sv
// Shared widths, width-derivation helpers, FSM state encoding and saturation
// helper for the affine datapath and its inverse solver.
package affine_pkg;

  localparam int WLX_DEF = 8;
  localparam int WLA_DEF = 3;
  localparam int WLB_DEF = 4;
  localparam int WLC_DEF = 5;

  function automatic int calc_wlregm(input int wlx, input int wla);
    return wlx + wla;
  endfunction

  function automatic int calc_wlrega(input int wlregm, input int wlb);
    return ((wlregm > wlb) ? wlregm : wlb) + 1;
  endfunction

  function automatic int calc_wly(input int wlrega, input int wlc);
    return wlrega + wlc;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DIV_C = 3'd2,
    S_SUB_B = 3'd3,
    S_DIV_A = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Clamp v to the signed range of a w-bit number; caller truncates to w bits.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                    input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/seq_sdiv.sv
// Restoring radix-2 signed divider: quotient truncates toward zero and the
// remainder carries the dividend's sign. done pulses W+1 cycles after start.
module seq_sdiv #(
  parameter int W = 19
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic signed [W-1:0] dividend,
  input  logic signed [W-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] quot,
  output logic signed [W-1:0] rem
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic [W:0]    trial;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    trial  = {rem_q, quo_q[W-1]};
    done   = busy_q && (cnt_q == '0);
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(W);
      rem_d  = '0;
      quo_d  = dividend[W-1] ? $unsigned(-dividend) : $unsigned(dividend);
      dvs_d  = divisor[W-1] ? $unsigned(-divisor) : $unsigned(divisor);
      qneg_d = dividend[W-1] ^ divisor[W-1];
      rneg_d = dividend[W-1];
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
        if (trial >= {1'b0, dvs_q}) begin
          rem_d = W'(trial - {1'b0, dvs_q});
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = trial[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) busy_q <= 1'b0;
    else      busy_q <= busy_d;
    cnt_q  <= cnt_d;
    quo_q  <= quo_d;
    rem_q  <= rem_d;
    dvs_q  <= dvs_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

  assign busy = busy_q;
  assign quot = qneg_q ? -$signed(quo_q) : $signed(quo_q);
  assign rem  = rneg_q ? -$signed(rem_q) : $signed(rem_q);

endmodule

// File: rtl/affine_inverse_solver.sv
// Recovers x = ((y / c) - b) / a from a forward affine result using one shared
// iterative signed divider; one transaction at a time, valid/ready on both sides.
module affine_inverse_solver
  import affine_pkg::*;
#(
  parameter  int WLx    = WLX_DEF,
  parameter  int WLa    = WLA_DEF,
  parameter  int WLb    = WLB_DEF,
  parameter  int WLc    = WLC_DEF,
  localparam int WLregm = calc_wlregm(WLx, WLa),
  localparam int WLrega = calc_wlrega(WLregm, WLb),
  localparam int WLy    = calc_wly(WLrega, WLc),
  localparam int WLd    = WLy + 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [WLy-1:0] y,
  input  logic signed [WLa-1:0] a,
  input  logic signed [WLb-1:0] b,
  input  logic signed [WLc-1:0] c,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [WLx-1:0] x,
  output logic                  exact,
  output logic                  ovf,
  output logic                  dz
);

  state_e                state_q, state_d;
  logic signed [WLd-1:0] y_q, y_d, a_q, a_d, b_q, b_d, c_q, c_d;
  logic signed [WLd-1:0] q1_q, q1_d;
  logic                  r1z_q, r1z_d;
  logic signed [WLx-1:0] x_q, x_d;
  logic                  exact_q, exact_d, ovf_q, ovf_d, dz_q, dz_d;

  logic                  div_start, div_busy, div_done;
  logic signed [WLd-1:0] div_dividend, div_divisor, div_quot, div_rem;
  logic signed [31:0]    q2_wide, q2_sat;

  seq_sdiv #(.W(WLd)) u_div (
    .CLK      (CLK),
    .RST      (RST),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  assign in_ready  = RST && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign q2_wide   = 32'(div_quot);
  assign q2_sat    = sat_signed(q2_wide, WLx);

  always_comb begin
    state_d      = state_q;
    y_d          = y_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    q1_d         = q1_q;
    r1z_d        = r1z_q;
    x_d          = x_q;
    exact_d      = exact_q;
    ovf_d        = ovf_q;
    dz_d         = dz_q;
    div_start    = 1'b0;
    div_dividend = y_q;
    div_divisor  = c_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          y_d = WLd'(y);
          a_d = WLd'(a);
          b_d = WLd'(b);
          c_d = WLd'(c);
          // A zero divisor skips both divisions and reports straight away.
          if (a == '0 || c == '0) begin
            x_d     = '0;
            exact_d = 1'b0;
            ovf_d   = 1'b0;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        div_start    = !div_busy;
        div_dividend = y_q;
        div_divisor  = c_q;
        state_d      = S_DIV_C;
      end
      S_DIV_C: begin
        if (div_done) begin
          q1_d    = div_quot;
          r1z_d   = (div_rem == '0);
          state_d = S_SUB_B;
        end
      end
      S_SUB_B: begin
        div_start    = !div_busy;
        div_dividend = q1_q - b_q;
        div_divisor  = a_q;
        state_d      = S_DIV_A;
      end
      S_DIV_A: begin
        if (div_done) begin
          x_d     = WLx'(q2_sat);
          ovf_d   = (q2_sat != q2_wide);
          exact_d = r1z_q && (div_rem == '0) && (q2_sat == q2_wide);
          dz_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      exact_q <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      exact_q <= exact_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
    y_q   <= y_d;
    a_q   <= a_d;
    b_q   <= b_d;
    c_q   <= c_d;
    q1_q  <= q1_d;
    r1z_q <= r1z_d;
  end

  assign x     = x_q;
  assign exact = exact_q;
  assign ovf   = ovf_q;
  assign dz    = dz_q;

endmodule

// File: tb/tb_affine_inverse_solver.sv
// Bench for affine_inverse_solver: directed vector table, hold/reset sequences
// and randomized transactions against a plain-arithmetic reference model.
module tb_affine_inverse_solver;

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [16:0] y = '0;
  logic signed [2:0]  a = '0;
  logic signed [3:0]  b = '0;
  logic signed [4:0]  c = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [7:0]  x;
  logic               exact, ovf, dz;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int y, a, b, c;
    int x, ex, ov, dz;
  } vec_t;
  vec_t tbl [10];

  int rx, rex, rov, rdz, lat;
  int ex_x, ex_ex, ex_ov, ex_dz;
  int yi, ai, bi, ci, xi;
  int hx, hex, seen;

  affine_inverse_solver dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .exact     (exact),
    .ovf       (ovf),
    .dz        (dz)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void ref_model(input int yv, input int av, input int bv, input int cv,
                                    output int xo, output int exo, output int ovo,
                                    output int dzo);
    int q1, r1, s, q2, r2;
    if (av == 0 || cv == 0) begin
      xo = 0; exo = 0; ovo = 0; dzo = 1;
      return;
    end
    q1 = yv / cv;
    r1 = yv % cv;
    s  = q1 - bv;
    q2 = s / av;
    r2 = s % av;
    dzo = 0;
    if (q2 > 127)       begin xo = 127;  ovo = 1; end
    else if (q2 < -128) begin xo = -128; ovo = 1; end
    else                begin xo = q2;   ovo = 0; end
    exo = (r1 == 0 && r2 == 0 && ovo == 0) ? 1 : 0;
  endfunction

  task automatic do_txn(input int yv, input int av, input int bv, input int cv,
                        output int xo, output int exo, output int ovo, output int dzo,
                        output int lo);
    int w;
    @(negedge CLK);
    y = 17'(yv); a = 3'(av); b = 4'(bv); c = 5'(cv);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge CLK);
      w++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    @(posedge CLK);
    #1;
    // Keep in_valid up with junk operands while busy: it must be ignored.
    y = 17'($urandom); a = 3'($urandom); b = 4'($urandom); c = 5'($urandom);
    lo = 0;
    do begin
      @(negedge CLK);
      lo++;
    end while (!out_valid && lo < 200);
    in_valid = 1'b0;
    xo = int'(x); exo = int'(exact); ovo = int'(ovf); dzo = int'(dz);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge CLK);
    #1 out_ready = 1'b0;
    @(negedge CLK);
    chk("out_valid_after_release", out_valid, 0);
    chk("in_ready_after_release", in_ready, 1);
  endtask

  initial begin
    tbl[0] = '{y:    91, a:  3, b: -2, c:   7, x:    5, ex: 1, ov: 0, dz: 0};
    tbl[1] = '{y: -8304, a: -4, b:  7, c: -16, x: -128, ex: 1, ov: 0, dz: 0};
    tbl[2] = '{y:    92, a:  3, b: -2, c:   7, x:    5, ex: 0, ov: 0, dz: 0};
    tbl[3] = '{y:   -92, a:  3, b: -2, c:   7, x:   -3, ex: 0, ov: 0, dz: 0};
    tbl[4] = '{y: 65535, a:  1, b:  0, c:   1, x:  127, ex: 0, ov: 1, dz: 0};
    tbl[5] = '{y:-65536, a:  1, b:  0, c:  -1, x:  127, ex: 0, ov: 1, dz: 0};
    tbl[6] = '{y:  1234, a:  2, b:  3, c:   0, x:    0, ex: 0, ov: 0, dz: 1};
    tbl[7] = '{y:    -5, a:  0, b:  1, c:   3, x:    0, ex: 0, ov: 0, dz: 1};
    tbl[8] = '{y:-65536, a:  1, b:  0, c:   1, x: -128, ex: 0, ov: 1, dz: 0};
    tbl[9] = '{y:     0, a: -1, b: -8, c: -16, x:   -8, ex: 1, ov: 0, dz: 0};

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_x", x, 0);
    chk("rst_exact", exact, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dz", dz, 0);
    RST = 1'b1;
    @(negedge CLK);
    chk("idle_in_ready", in_ready, 1);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      do_txn(tbl[i].y, tbl[i].a, tbl[i].b, tbl[i].c, rx, rex, rov, rdz, lat);
      chk($sformatf("tbl%0d_x", i), rx, tbl[i].x);
      chk($sformatf("tbl%0d_exact", i), rex, tbl[i].ex);
      chk($sformatf("tbl%0d_ovf", i), rov, tbl[i].ov);
      chk($sformatf("tbl%0d_dz", i), rdz, tbl[i].dz);
      chk($sformatf("tbl%0d_latency", i), lat, (tbl[i].dz != 0) ? 1 : 43);
      release_out();
    end

    // Output hold under back-pressure
    do_txn(91, 3, -2, 7, rx, rex, rov, rdz, lat);
    hx = rx; hex = rex;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_x", x, 5);
      chk("hold_exact", exact, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    chk("hold_initial_x", hx, 5);
    chk("hold_initial_exact", hex, 1);
    release_out();

    // Reset while the first division is running
    @(negedge CLK);
    y = 17'(-8304); a = 3'(-4); b = 4'(7); c = 5'(-16);
    in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_x", x, 0);
    chk("midrst_exact", exact, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_dz", dz, 0);
    chk("midrst_in_ready", in_ready, 0);
    RST = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (out_valid) seen = 1;
    end
    chk("midrst_no_stale_result", seen, 0);
    chk("midrst_idle_after", in_ready, 1);

    // Random forward round-trips: y built by the forward datapath must invert exactly
    for (int i = 0; i < 20; i++) begin
      xi = int'($urandom_range(255)) - 128;
      do ai = int'($urandom_range(7)) - 4; while (ai == 0);
      bi = int'($urandom_range(15)) - 8;
      do ci = int'($urandom_range(31)) - 16; while (ci == 0);
      yi = (xi * ai + bi) * ci;
      do_txn(yi, ai, bi, ci, rx, rex, rov, rdz, lat);
      chk($sformatf("fwd%0d_x", i), rx, xi);
      chk($sformatf("fwd%0d_exact", i), rex, 1);
      chk($sformatf("fwd%0d_ovf", i), rov, 0);
      chk($sformatf("fwd%0d_latency", i), lat, 43);
      release_out();
    end

    // Random arbitrary operands against the reference model
    for (int i = 0; i < 20; i++) begin
      yi = int'($urandom_range(131071)) - 65536;
      ai = int'($urandom_range(7)) - 4;
      bi = int'($urandom_range(15)) - 8;
      ci = int'($urandom_range(31)) - 16;
      ref_model(yi, ai, bi, ci, ex_x, ex_ex, ex_ov, ex_dz);
      do_txn(yi, ai, bi, ci, rx, rex, rov, rdz, lat);
      chk($sformatf("rnd%0d_x", i), rx, ex_x);
      chk($sformatf("rnd%0d_exact", i), rex, ex_ex);
      chk($sformatf("rnd%0d_ovf", i), rov, ex_ov);
      chk($sformatf("rnd%0d_dz", i), rdz, ex_dz);
      chk($sformatf("rnd%0d_latency", i), lat, (ex_dz != 0) ? 1 : 43);
      release_out();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
